load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage sitting directly downstream of the ALU in the single-cycle RISC-V core. It takes the ALU result as the effective address, the second register operand as store data, and the control unit's `mem_read`/`mem_write`. It runs a request/acknowledge transaction on a data bus with variable latency, stalling the core until the access completes. It aligns byte and halfword data, sign- or zero-extends loads, and returns the load result with its destination register for writeback.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum cycles in REQ without `bus_ack` before entering ERR; range 1–255, 8-bit counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low; sampled on rising edge of `clk`
- `mem_read`  in  1  load requested by current instruction
- `mem_write`  in  1  store requested by current instruction
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `addr`  in  32  effective byte address (ALU result)
- `store_data`  in  32  store operand (rs2 value)
- `rd`  in  5  load destination register
- `stall`  out  1  hold PC/instruction; combinational
- `load_valid`  out  1  one-cycle pulse: `load_data`/`load_rd` valid for writeback
- `load_data`  out  32  aligned, extended load result
- `load_rd`  out  5  destination of completed load
- `bus_req`  out  1  bus request, held until ack
- `bus_we`  out  1  1 = write
- `bus_addr`  out  32  word address, `{addr[31:2],2'b00}`
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  32  lane-replicated store data
- `bus_ack`  in  1  bus completion; rdata valid same cycle
- `bus_rdata`  in  32  read word
- `err`  out  1  sticky fault (timeout or misalign)

## Operation
- States: IDLE, REQ, RESP, ERR.
- IDLE: if `mem_read|mem_write`, capture addr, funct3, store_data, rd, and direction; go to REQ. `stall`=1 in that cycle.
- Both `mem_read` and `mem_write` high: performed as a store; no `load_valid`.
- REQ: `bus_req`=1, bus fields constant from captured values; `stall`=1. On `bus_ack`: latch extracted load data and go to RESP. Otherwise increment counter; when counter reaches `TIMEOUT_CYCLES`, go to ERR.
- RESP: `stall`=0, `load_valid`=1 for loads only; inputs ignored (same instruction still presented); go to IDLE.
- ERR: `err`=1, `bus_req`=0, `stall`=1. Held until reset.
- Store lanes:
  - SB: `bus_be`=`0001<<addr[1:0]`, byte replicated ×4.
  - SH: `bus_be`=`0011<<{addr[1],1'b0}`, half replicated ×2.
  - SW: `1111`.
- Load: `bus_rdata >> (8*addr[1:0])`; B/H sign-extend, BU/HU zero-extend; W unmodified.
- Undefined funct3 (011, 110, 111): treated as W.
- `bus_ack` outside REQ is ignored.

## Timing
- Minimum access is 3 cycles: IDLE (accept, cycle T), REQ (T+1, ack same cycle), RESP (T+2). `load_valid` rises at T+2.
- Ack arriving at REQ cycle k gives RESP at k+1.
- Ack in the same cycle the counter hits the limit: ack wins, RESP.
- Reset values: `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_be`=0, `bus_wdata`=0, `load_valid`=0, `load_data`=0, `load_rd`=0, `err`=0, counter=0; state IDLE. `stall`=0 while `reset`=0.
- Reset asserted in any state (including mid-REQ): IDLE on the next edge, bus request dropped immediately.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0, goes IDLE→ERR directly; no bus request is issued.
- Undefined: misaligned low bits are forced to natural alignment (H ignores `addr[0]`, W ignores `addr[1:0]`) and the access proceeds normally.

## Test plan
- LW `addr`=0x100, ack on first REQ cycle, rdata=0xDEADBEEF → `bus_addr`=0x100, `bus_be`=1111; `load_valid` on cycle 3 with `load_data`=0xDEADBEEF; `stall` high for exactly 2 cycles.
- LB `addr`=0x103, rdata=0x80112233 → `load_data`=0xFFFFFF80. LBU same access → 0x00000080. LHU `addr`=0x102 → 0x00008011.
- SB `addr`=0x201, `store_data`=0x000000A5, ack after 4 REQ cycles → `bus_be`=0010, `bus_wdata`=0xA5A5A5A5, `bus_we`=1; `stall` high 5 cycles; `load_valid` stays 0.
- `TIMEOUT_CYCLES`=4, no ack → ERR after 4 REQ cycles: `err`=1, `bus_req`=0, `stall`=1. Reset low one edge → all outputs at reset values; next LW completes normally.
- SW `addr`=0x302 → with `LSU_MISALIGN_TRAP_EN`: `err`=1, no `bus_req` ever. Without it: `bus_addr`=0x300, `bus_be`=1111.
- Reset asserted during REQ with ack arriving on the same edge → IDLE; no `load_valid`; `bus_req`=0 the next cycle.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-bus bundle for load_store_unit: request/acknowledge handshake with word address,
// byte enables and lane-replicated write data.
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Data-memory stage: variable-latency req/ack bus access, byte/half lane alignment, load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses fault instead of being force-aligned.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    input  logic [4:0]        rd,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic [4:0]        load_rd,
    output logic              err,
    load_store_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  count;
    logic        req_q;
    logic        we_q;
    logic        is_load_q;
    logic        unsigned_q;
    size_t       size_q;
    logic [1:0]  offset_q;
    logic [4:0]  rd_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    size_t       size_in;
    logic [1:0]  offset_in;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [31:0] shifted;
    logic [31:0] extracted;

    // Undefined funct3 encodings fall through to word; H and W low address bits are dropped.
    always_comb begin
        size_in   = SZ_W;
        offset_in = 2'b00;
        be_in     = 4'b1111;
        wdata_in  = store_data;
        case (funct3[1:0])
            2'b00: begin
                size_in   = SZ_B;
                offset_in = addr[1:0];
                be_in     = 4'b0001 << addr[1:0];
                wdata_in  = {4{store_data[7:0]}};
            end
            2'b01: begin
                size_in   = SZ_H;
                offset_in = {addr[1], 1'b0};
                be_in     = 4'b0011 << {addr[1], 1'b0};
                wdata_in  = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = bus.bus_rdata >> {offset_q, 3'b000};
        extracted = shifted;
        case (size_q)
            SZ_B:    extracted = unsigned_q ? {24'd0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    extracted = unsigned_q ? {16'd0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (size_in == SZ_H && addr[0]) ||
                        (size_in == SZ_W && addr[1:0] != 2'b00);
`endif

    // Reset gates stall and the bus request so both drop in the cycle reset is asserted.
    assign stall = reset && ((state == IDLE && (mem_read || mem_write)) ||
                             state == REQ || state == ERR);

    assign bus.bus_req   = req_q && reset;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= 8'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            is_load_q  <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= SZ_W;
            offset_q   <= 2'b00;
            rd_q       <= 5'd0;
            addr_q     <= 32'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            load_valid <= 1'b0;
            load_data  <= 32'd0;
            load_rd    <= 5'd0;
            err        <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        we_q       <= mem_write;
                        is_load_q  <= mem_read && !mem_write;
                        unsigned_q <= funct3[2];
                        size_q     <= size_in;
                        offset_q   <= offset_in;
                        rd_q       <= rd;
                        addr_q     <= {addr[31:2], 2'b00};
                        be_q       <= be_in;
                        wdata_q    <= wdata_in;
                        count      <= 8'd0;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            err   <= 1'b1;
                            state <= ERR;
                        end else begin
                            req_q <= 1'b1;
                            state <= REQ;
                        end
`else
                        req_q <= 1'b1;
                        state <= REQ;
`endif
                    end
                end
                // Ack takes priority over the timeout when both land in the same cycle.
                REQ: begin
                    if (bus.bus_ack) begin
                        req_q      <= 1'b0;
                        load_valid <= is_load_q;
                        if (is_load_q) begin
                            load_data <= extracted;
                            load_rd   <= rd_q;
                        end
                        state <= RESP;
                    end else if (count == LIMIT) begin
                        req_q <= 1'b0;
                        err   <= 1'b1;
                        state <= ERR;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                RESP:    state <= IDLE;
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected bus requests and loads,
// a forked monitor pops and compares them whenever the DUT presents them.
module tb_load_store_unit;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_be;
        logic        chk_wdata;
    } bus_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
    } load_exp_t;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic [4:0]  load_rd;
    logic        err;

    load_store_unit_if bus_if();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .rd         (rd),
        .stall      (stall),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_rd    (load_rd),
        .err        (err),
        .bus        (bus_if)
    );

    int checks = 0;
    int errors = 0;
    bus_exp_t  bus_q[$];
    load_exp_t load_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic expectBus(input logic we, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd, input logic cbe, input logic cwd);
        bus_exp_t e;
        e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.chk_be = cbe; e.chk_wdata = cwd;
        bus_q.push_back(e);
    endtask

    task automatic expectLoad(input logic [31:0] d, input logic [4:0] r);
        load_exp_t e;
        e.data = d; e.rd = r;
        load_q.push_back(e);
    endtask

    // Compares each new bus request and each load_valid pulse against the queue heads.
    task automatic monitor();
        logic     seen_req;
        bus_exp_t be_e;
        load_exp_t ld_e;
        seen_req = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.bus_req === 1'b1 && !seen_req) begin
                if (bus_q.size() == 0) begin
                    checkOutput("unexpected_bus_req", 32'(bus_if.bus_req), 32'd0);
                end else begin
                    be_e = bus_q.pop_front();
                    checkOutput("bus_we", 32'(bus_if.bus_we), 32'(be_e.we));
                    checkOutput("bus_addr", bus_if.bus_addr, be_e.addr);
                    if (be_e.chk_be) checkOutput("bus_be", 32'(bus_if.bus_be), 32'(be_e.be));
                    if (be_e.chk_wdata) checkOutput("bus_wdata", bus_if.bus_wdata, be_e.wdata);
                end
            end
            seen_req = (bus_if.bus_req === 1'b1);
            if (load_valid !== 1'b0) begin
                if (load_q.size() == 0) begin
                    checkOutput("unexpected_load_valid", 32'(load_valid), 32'd0);
                end else begin
                    ld_e = load_q.pop_front();
                    checkOutput("load_data", load_data, ld_e.data);
                    checkOutput("load_rd", 32'(load_rd), 32'(ld_e.rd));
                end
            end
        end
    endtask

    // Presents one instruction and plays the memory: ack in the ack_after-th REQ cycle (0 = never).
    task automatic applyStimulus(input string tag, input logic mr, input logic mw, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                                 input int ack_after, input logic [31:0] rdata,
                                 output int stall_cycles, output int req_cycles, output logic lv_at_end);
        logic done;
        mem_read = mr; mem_write = mw; funct3 = f3; addr = a; store_data = sd; rd = r;
        stall_cycles = 0; req_cycles = 0; lv_at_end = 1'b0; done = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (stall !== 1'b1) begin
                lv_at_end = load_valid;
                done = 1'b1;
                break;
            end
            stall_cycles++;
            if (err === 1'b1) begin
                done = 1'b1;
                break;
            end
            if (bus_if.bus_req === 1'b1) begin
                req_cycles++;
                if (req_cycles == ack_after) begin
                    bus_if.bus_ack = 1'b1;
                    bus_if.bus_rdata = rdata;
                end
            end
            @(posedge clk); #1;
            bus_if.bus_ack = 1'b0;
        end
        checkOutput({tag, "_terminated"}, 32'(done), 32'd1);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
        checkOutput({tag, "_bus_req"}, 32'(bus_if.bus_req), 32'd0);
        checkOutput({tag, "_bus_we"}, 32'(bus_if.bus_we), 32'd0);
        checkOutput({tag, "_bus_addr"}, bus_if.bus_addr, 32'd0);
        checkOutput({tag, "_bus_be"}, 32'(bus_if.bus_be), 32'd0);
        checkOutput({tag, "_bus_wdata"}, bus_if.bus_wdata, 32'd0);
        checkOutput({tag, "_load_valid"}, 32'(load_valid), 32'd0);
        checkOutput({tag, "_load_data"}, load_data, 32'd0);
        checkOutput({tag, "_load_rd"}, 32'(load_rd), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Holds reset low across exactly one rising edge, then releases it.
    task automatic pulseReset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput({tag, "_stall_in_reset"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkResetState(tag);
        @(posedge clk); #1;
    endtask

    initial begin
        int   sc;
        int   rc;
        logic lv;

        fork
            monitor();
        join_none

        reset = 1'b0; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        addr = 32'h100; store_data = 32'h0; rd = 5'd1;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
        $display("[TB] reset and power-on state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetState("por");
        mem_read = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        $display("[TB] loads with alignment and extension");
        expectBus(1'b0, 32'h100, 4'b1111, 32'h0, 1'b1, 1'b0);
        expectLoad(32'hDEADBEEF, 5'd5);
        applyStimulus("lw", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 1, 32'hDEADBEEF, sc, rc, lv);
        checkOutput("lw_stall_cycles", 32'(sc), 32'd2);
        checkOutput("lw_valid_cycle3", 32'(lv), 32'd1);

        expectBus(1'b0, 32'h100, 4'b0, 32'h0, 1'b0, 1'b0);
        expectLoad(32'hFFFFFF80, 5'd6);
        applyStimulus("lb", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 1, 32'h80112233, sc, rc, lv);

        expectBus(1'b0, 32'h100, 4'b0, 32'h0, 1'b0, 1'b0);
        expectLoad(32'h00000080, 5'd6);
        applyStimulus("lbu", 1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd6, 1, 32'h80112233, sc, rc, lv);

        expectBus(1'b0, 32'h100, 4'b0, 32'h0, 1'b0, 1'b0);
        expectLoad(32'h00008011, 5'd7);
        applyStimulus("lhu", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 5'd7, 1, 32'h80112233, sc, rc, lv);

        expectBus(1'b0, 32'h100, 4'b0, 32'h0, 1'b0, 1'b0);
        expectLoad(32'hFFFF8011, 5'd8);
        applyStimulus("lh", 1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd8, 1, 32'h80112233, sc, rc, lv);

        expectBus(1'b0, 32'h104, 4'b1111, 32'h0, 1'b1, 1'b0);
        expectLoad(32'hCAFEF00D, 5'd11);
        applyStimulus("f3_011", 1'b1, 1'b0, 3'b011, 32'h104, 32'h0, 5'd11, 1, 32'hCAFEF00D, sc, rc, lv);

        $display("[TB] stores and lane replication");
        expectBus(1'b1, 32'h200, 4'b0010, 32'hA5A5A5A5, 1'b1, 1'b1);
        applyStimulus("sb", 1'b0, 1'b1, 3'b000, 32'h201, 32'h000000A5, 5'd0, 4, 32'h0, sc, rc, lv);
        checkOutput("sb_stall_cycles", 32'(sc), 32'd5);
        checkOutput("sb_req_cycles", 32'(rc), 32'd4);
        checkOutput("sb_no_load_valid", 32'(lv), 32'd0);
        checkOutput("sb_err", 32'(err), 32'd0);

        expectBus(1'b1, 32'h200, 4'b1100, 32'hBEEFBEEF, 1'b1, 1'b1);
        applyStimulus("sh", 1'b0, 1'b1, 3'b001, 32'h202, 32'h1234BEEF, 5'd0, 2, 32'h0, sc, rc, lv);
        checkOutput("sh_stall_cycles", 32'(sc), 32'd3);

        expectBus(1'b1, 32'h400, 4'b1111, 32'h11223344, 1'b1, 1'b1);
        applyStimulus("rw_both", 1'b1, 1'b1, 3'b010, 32'h400, 32'h11223344, 5'd12, 1, 32'hFFFFFFFF, sc, rc, lv);
        checkOutput("rw_both_no_load_valid", 32'(lv), 32'd0);

        $display("[TB] misaligned word store");
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus("sw_mis", 1'b0, 1'b1, 3'b010, 32'h302, 32'h55AA55AA, 5'd0, 1, 32'h0, sc, rc, lv);
        checkOutput("sw_mis_req_cycles", 32'(rc), 32'd0);
        @(negedge clk);
        checkOutput("sw_mis_err", 32'(err), 32'd1);
        checkOutput("sw_mis_bus_req", 32'(bus_if.bus_req), 32'd0);
        pulseReset("sw_mis_rst");
`else
        expectBus(1'b1, 32'h300, 4'b1111, 32'h55AA55AA, 1'b1, 1'b1);
        applyStimulus("sw_mis", 1'b0, 1'b1, 3'b010, 32'h302, 32'h55AA55AA, 5'd0, 1, 32'h0, sc, rc, lv);
        checkOutput("sw_mis_err", 32'(err), 32'd0);
`endif

        $display("[TB] timeout and recovery");
        expectBus(1'b0, 32'h500, 4'b1111, 32'h0, 1'b1, 1'b0);
        applyStimulus("timeout", 1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 5'd3, 0, 32'h0, sc, rc, lv);
        checkOutput("timeout_req_cycles", 32'(rc), 32'd4);
        @(negedge clk);
        checkOutput("timeout_err", 32'(err), 32'd1);
        checkOutput("timeout_bus_req", 32'(bus_if.bus_req), 32'd0);
        checkOutput("timeout_stall", 32'(stall), 32'd1);
        pulseReset("timeout_rst");

        expectBus(1'b0, 32'h600, 4'b1111, 32'h0, 1'b1, 1'b0);
        expectLoad(32'h0BADF00D, 5'd9);
        applyStimulus("lw_after", 1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 5'd9, 2, 32'h0BADF00D, sc, rc, lv);
        checkOutput("lw_after_stall_cycles", 32'(sc), 32'd3);
        checkOutput("lw_after_valid", 32'(lv), 32'd1);

        $display("[TB] reset during REQ with simultaneous ack");
        expectBus(1'b0, 32'h700, 4'b1111, 32'h0, 1'b1, 1'b0);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h700; rd = 5'd10;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_req_bus_req", 32'(bus_if.bus_req), 32'd1);
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rdata = 32'h12345678;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; bus_if.bus_ack = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_bus_req_after", 32'(bus_if.bus_req), 32'd0);
        checkOutput("rst_req_load_valid", 32'(load_valid), 32'd0);
        checkOutput("rst_req_stall", 32'(stall), 32'd0);
        @(negedge clk);
        checkOutput("rst_req_load_valid_2", 32'(load_valid), 32'd0);

        repeat (2) @(negedge clk);
        checkOutput("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        checkOutput("load_queue_drained", 32'(load_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
